// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle.
// Groups the hazard/redirect inputs coming from decode, the instruction
// memory read port and the IF/ID pipeline register outputs.
//   master : the fetch unit (drives PC, IF/ID, opcode, fetch_count)
//   slave  : the surrounding pipeline / memory model
interface instruction_fetch_unit_if;
  // from hazard unit / decode stage
  logic        stall;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;
  logic        zero;
  logic [31:0] branch_imm;
  // instruction memory read port (combinational read)
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  // IF/ID pipeline register
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_eq, branch_ne, jump, zero, branch_imm, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, opcode,
           fetch_count
  );

  modport slave (
    output stall, branch_eq, branch_ne, jump, zero, branch_imm, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, opcode,
           fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage with a single IF/ID pipeline register.
// Fetches one word per cycle at the PC, redirects on taken BEQ/BNE or J
// resolved in decode (one-cycle bubble), and holds everything on stall.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : instruction_fetch_unit_if.master (decode controls in,
//            imem port, IF/ID register, opcode, fetch_count out)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_fetch_unit_if.master      bus
);

  logic [31:0] pcQ;
  logic [31:0] instrQ;
  logic [31:0] pc4Q;
  logic        validQ;
  logic [31:0] cntQ;

  logic        taken;
  logic        jumpTaken;
  logic        redirect;
  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] nextPc;

  // Redirect decisions only count for a real instruction in decode; a
  // bubble must never steer the PC even if stale control bits are high.
  assign taken     = validQ & ((bus.branch_eq & bus.zero) |
                               (bus.branch_ne & ~bus.zero));
  assign jumpTaken = validQ & bus.jump;
  assign redirect  = taken | jumpTaken;

  assign pcPlus4      = pcQ + 32'd4;
  assign branchTarget = pc4Q + {bus.branch_imm[29:0], 2'b00};
  assign jumpTarget   = {pc4Q[31:28], instrQ[25:0], 2'b00};

  // Jump has priority over a simultaneously taken branch.
  always_comb begin
    nextPc = pcPlus4;
    if (jumpTaken)  nextPc = jumpTarget;
    else if (taken) nextPc = branchTarget;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcQ    <= RESET_PC;
      instrQ <= NOP_WORD;
      pc4Q   <= 32'd0;
      validQ <= 1'b0;
      cntQ   <= 32'd0;
    end else if (!bus.stall) begin
      // Word alignment is enforced on every PC load.
      pcQ <= {nextPc[31:2], 2'b00};
      if (redirect) begin
        // Squash the wrong-path word fetched this cycle.
        instrQ <= NOP_WORD;
        pc4Q   <= 32'd0;
        validQ <= 1'b0;
      end else begin
        instrQ <= bus.imem_data;
        pc4Q   <= pcPlus4;
        validQ <= 1'b1;
        cntQ   <= cntQ + 32'd1;
      end
    end
  end

  assign bus.imem_addr      = pcQ;
  assign bus.if_id_instr    = instrQ;
  assign bus.if_id_pc_plus4 = pc4Q;
  assign bus.if_id_valid    = validQ;
  assign bus.opcode         = instrQ[31:26];
  assign bus.fetch_count    = cntQ;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  logic clk;
  logic reset;
  int   errCnt = 0;
  int   chkCnt = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC(32'h0040_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: address 0x0040000C holds a J with target field
  // 26'h0100010; every other word is {6'h23, addr[25:0]}.
  function automatic logic [31:0] imemWord(input logic [31:0] a);
    if (a == 32'h0040_000C) return 32'h0810_0010;
    return {6'h23, a[25:0]};
  endfunction

  assign bus.imem_data = imemWord(bus.imem_addr);

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expState(input string t, input logic [31:0] addr,
                          input logic [31:0] instr, input logic [31:0] pc4,
                          input logic vld, input logic [31:0] cnt);
    checkVal({t, ".addr"},  bus.imem_addr, addr);
    checkVal({t, ".instr"}, bus.if_id_instr, instr);
    checkVal({t, ".pc4"},   bus.if_id_pc_plus4, pc4);
    checkVal({t, ".vld"},   {31'd0, bus.if_id_valid}, {31'd0, vld});
    checkVal({t, ".cnt"},   bus.fetch_count, cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic beq, input logic bne, input logic j,
                     input logic z, input logic [31:0] imm);
    bus.branch_eq  = beq;
    bus.branch_ne  = bne;
    bus.jump       = j;
    bus.zero       = z;
    bus.branch_imm = imm;
  endtask

  initial begin
    reset     = 1'b0;
    bus.stall = 1'b0;
    ctl(0, 0, 0, 0, 32'd0);

    // reset held across an edge
    step();
    expState("rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b1;

    // sequential fetch
    step();
    expState("seq1", 32'h0040_0004, 32'h8C40_0000, 32'h0040_0004, 1'b1, 32'd1);
    checkVal("seq1.opcode", {26'd0, bus.opcode}, 32'h23);
    step();
    expState("seq2", 32'h0040_0008, 32'h8C40_0004, 32'h0040_0008, 1'b1, 32'd2);
    step();
    expState("seq3", 32'h0040_000C, 32'h8C40_0008, 32'h0040_000C, 1'b1, 32'd3);

    // BNE with zero=1: not taken
    ctl(0, 1, 0, 1, 32'hFFFF_FFFE);
    step();
    expState("bneNt", 32'h0040_0010, 32'h0810_0010, 32'h0040_0010, 1'b1, 32'd4);
    checkVal("bneNt.opcode", {26'd0, bus.opcode}, 32'h02);

    // J plus taken BEQ together: jump wins
    ctl(1, 0, 1, 1, 32'hFFFF_FFFE);
    step();
    expState("jmp", 32'h0040_0040, 32'h0, 32'h0, 1'b0, 32'd4);

    // controls left high during the bubble must be ignored
    step();
    expState("bubble", 32'h0040_0044, 32'h8C40_0040, 32'h0040_0044, 1'b1, 32'd5);
    ctl(0, 0, 0, 0, 32'd0);

    // fresh start for the BEQ scenario at pc_plus4 = 0x00400008
    reset = 1'b0;
    #1;
    expState("rst2", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    reset = 1'b1;
    step();
    step();
    expState("pre", 32'h0040_0008, 32'h8C40_0004, 32'h0040_0008, 1'b1, 32'd2);
    ctl(1, 0, 0, 1, 32'hFFFF_FFFE);
    step();
    expState("beq", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd2);
    ctl(0, 0, 0, 0, 32'd0);
    step();
    expState("beqTgt", 32'h0040_0004, 32'h8C40_0000, 32'h0040_0004, 1'b1, 32'd3);

    // stall with a pending taken BEQ (target 0x00400004 + 0x40)
    bus.stall = 1'b1;
    ctl(1, 0, 0, 1, 32'h0000_0010);
    for (int i = 0; i < 3; i++) begin
      step();
      expState($sformatf("stall%0d", i), 32'h0040_0004, 32'h8C40_0000,
               32'h0040_0004, 1'b1, 32'd3);
    end
    bus.stall = 1'b0;
    step();
    expState("unstall", 32'h0040_0044, 32'h0, 32'h0, 1'b0, 32'd3);
    ctl(0, 0, 0, 0, 32'd0);
    step();
    expState("refill", 32'h0040_0048, 32'h8C40_0044, 32'h0040_0048, 1'b1, 32'd4);

    // BNE with zero=0: taken, 0x00400048 - 8
    ctl(0, 1, 0, 0, 32'hFFFF_FFFE);
    step();
    expState("bneT", 32'h0040_0040, 32'h0, 32'h0, 1'b0, 32'd4);
    ctl(0, 0, 0, 0, 32'd0);
    step();
    expState("pre2", 32'h0040_0044, 32'h8C40_0040, 32'h0040_0044, 1'b1, 32'd5);

    // reset asserted mid-cycle while a redirect is pending
    ctl(1, 0, 0, 1, 32'hFFFF_FFFE);
    #2;
    reset = 1'b0;
    #1;
    expState("rstRedir", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    expState("rstHold", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b1;
    ctl(0, 0, 0, 0, 32'd0);
    step();
    expState("post", 32'h0040_0004, 32'h8C40_0000, 32'h0040_0004, 1'b1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
